// File: rtl/clint_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// clint_mem_responder_pkg
//   Shared definitions for the CLINT responder on the native mem_valid /
//   mem_ready bus. The register offsets inside the 64 KiB window, the
//   mtimecmp reset value, the handshake state type and a byte-lane merge
//   helper all live here.
//   The optional macro CLINT_MTIME_WRITE_EN, used by the top module, makes
//   mtime writable.
// ---------------------------------------------------------------------------
package clint_mem_responder_pkg;

   // Register offsets, measured from the window base (address bits 15:0)
   localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

   // mtimecmp comes out of reset at its maximum so that no timer interrupt
   // fires before software programs it
   localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // Two-state responder handshake
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   // Replace the byte lanes selected by strb with the lanes of newVal
   function automatic logic [31:0] applyStrobe(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      merged = oldVal;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = newVal[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/clint_mem_responder_prescaler.sv
// ---------------------------------------------------------------------------
// clint_mem_responder_prescaler
//   Divides the system clock down to the mtime tick rate. The counter runs
//   0..TICK_DIV-1, and tick is high for the one cycle in which it sits on its
//   last value. With TICK_DIV=1 the tick is high in every cycle.
// Ports
//   clk     in   system clock
//   resetn  in   asynchronous reset, active-low
//   tick    out  one-cycle mtime increment enable
// ---------------------------------------------------------------------------
module clint_mem_responder_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic resetn,
   output logic tick
);

   localparam logic [31:0] LP_LAST = 32'(TICK_DIV - 1);

   logic [31:0] r_count;

   assign tick = (r_count == LP_LAST);

   // Free-running divider: it restarts from zero in the cycle after each tick
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= 32'd0;
      end else if (tick) begin
         r_count <= 32'd0;
      end else begin
         r_count <= r_count + 32'd1;
      end
   end

endmodule

// File: rtl/clint_mem_responder.sv
// ---------------------------------------------------------------------------
// clint_mem_responder
//   Core-local interruptor acting as a responder on the core's native
//   mem_valid/mem_ready bus. It decodes its own 64 KiB window at BASE_ADDR and
//   holds msip, the 64-bit mtime counter and the 64-bit mtimecmp register.
//   It drives IRQ3 (msip) and IRQ7 (registered mtime >= mtimecmp).
//   Optional macro CLINT_MTIME_WRITE_EN: when it is defined, mtime lo/hi
//   accept byte-lane writes. Otherwise, writes to those offsets are acked
//   without a fault and then dropped.
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   mem_valid          request, held by the core until mem_ready
//   mem_ready          one-cycle response strobe
//   mem_wstrb          byte write enables, 0 means read
//   mem_addr/wdata     byte address and write data
//   mem_rdata          read data, driven only while mem_ready is high
//   access_fault       unmapped/misaligned strobe, coincides with mem_ready
//   IRQ3, IRQ7         software and timer interrupts
// ---------------------------------------------------------------------------
module clint_mem_responder
   import clint_mem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        access_fault,
   output logic        IRQ3,
   output logic        IRQ7
);

   state_t      r_state;
   state_t      w_nextState;
   logic        w_tick;
   logic        w_accept;
   logic        w_mapped;
   logic        w_write;
   logic [15:0] w_off;
   logic [31:0] w_readData;
   logic [31:0] r_rdata;
   logic        r_fault;
   logic        r_msip;
   logic [63:0] r_mtime;
   logic [63:0] r_mtimeCmp;
   logic        r_mtip;
   logic [63:0] w_mtimeInc;
   logic [63:0] w_mtimeNext;

   clint_mem_responder_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .resetn (resetn),
      .tick   (w_tick)
   );

   assign w_off    = mem_addr[15:0];
   // mem_valid is only sampled in IDLE, so the ACK cycle never starts a
   // second transaction
   assign w_accept = (r_state == ST_IDLE) && mem_valid &&
                     (mem_addr[31:16] == BASE_ADDR[31:16]);
   assign w_write  = w_accept && w_mapped && (mem_wstrb != 4'b0000);

   // Handshake state register. Reset is asynchronous, so mem_ready drops at
   // once when reset arrives in the middle of an ACK.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // ACK always lasts exactly one cycle
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_nextState = ST_ACK;
         ST_ACK:  w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Response outputs are exposed only during ACK and read as zero otherwise
   always_comb begin
      mem_ready    = 1'b0;
      mem_rdata    = 32'h0;
      access_fault = 1'b0;
      if (r_state == ST_ACK) begin
         mem_ready    = 1'b1;
         mem_rdata    = r_rdata;
         access_fault = r_fault;
      end
   end

   // Offset decode and read mux. Misaligned addresses never match an entry,
   // so they fall into the unmapped case together with the holes in the map.
   always_comb begin
      w_mapped   = 1'b1;
      w_readData = 32'h0;
      case (w_off)
         CLINT_MSIP_OFF:        w_readData = {31'b0, r_msip};
         CLINT_MTIMECMP_LO_OFF: w_readData = r_mtimeCmp[31:0];
         CLINT_MTIMECMP_HI_OFF: w_readData = r_mtimeCmp[63:32];
         CLINT_MTIME_LO_OFF:    w_readData = r_mtime[31:0];
         CLINT_MTIME_HI_OFF:    w_readData = r_mtime[63:32];
         default:               w_mapped   = 1'b0;
      endcase
   end

   // The response is captured on the accepting edge. In a tick cycle, reads
   // therefore return the value mtime had before the increment.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rdata <= 32'h0;
         r_fault <= 1'b0;
      end else if (w_accept) begin
         r_rdata <= w_readData;
         r_fault <= ~w_mapped;
      end
   end

   // msip and the two mtimecmp halves commit on the accepting edge. Each
   // mtimecmp half is written on its own, and the compare sees the live value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_msip     <= 1'b0;
         r_mtimeCmp <= CLINT_MTIMECMP_RST;
      end else if (w_write) begin
         if ((w_off == CLINT_MSIP_OFF) && mem_wstrb[0]) begin
            r_msip <= mem_wdata[0];
         end
         if (w_off == CLINT_MTIMECMP_LO_OFF) begin
            r_mtimeCmp[31:0] <= applyStrobe(r_mtimeCmp[31:0], mem_wdata, mem_wstrb);
         end
         if (w_off == CLINT_MTIMECMP_HI_OFF) begin
            r_mtimeCmp[63:32] <= applyStrobe(r_mtimeCmp[63:32], mem_wdata, mem_wstrb);
         end
      end
   end

   // Next mtime value. The increment, including the carry into the upper
   // half, is formed first. A bus write then replaces only the half it
   // targets, so the other half keeps its incremented value.
   always_comb begin
      w_mtimeInc  = w_tick ? (r_mtime + 64'd1) : r_mtime;
      w_mtimeNext = w_mtimeInc;
`ifdef CLINT_MTIME_WRITE_EN
      if (w_write && (w_off == CLINT_MTIME_LO_OFF)) begin
         w_mtimeNext[31:0] = applyStrobe(w_mtimeInc[31:0], mem_wdata, mem_wstrb);
      end
      if (w_write && (w_off == CLINT_MTIME_HI_OFF)) begin
         w_mtimeNext[63:32] = applyStrobe(w_mtimeInc[63:32], mem_wdata, mem_wstrb);
      end
`else
      w_mtimeNext = w_mtimeInc;
`endif
   end

   // mtime wraps silently from all-ones to zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mtime <= 64'd0;
      end else begin
         r_mtime <= w_mtimeNext;
      end
   end

   // The timer interrupt is registered from the live registers. It therefore
   // follows a change to either operand by one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mtip <= 1'b0;
      end else begin
         r_mtip <= (r_mtime >= r_mtimeCmp);
      end
   end

   assign IRQ3 = r_msip;
   assign IRQ7 = r_mtip;

endmodule

// File: tb/tb_clint_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_clint_mem_responder
//   Two responders share one bus: one with TICK_DIV=1 (index 0) and one with
//   TICK_DIV=4 (index 1). A register-level model tracks msip, mtime, mtimecmp
//   and the expected response for each of them. Every cycle their outputs are
//   compared against that model. Directed transfers add literal expectations.
// ---------------------------------------------------------------------------
module tb_clint_mem_responder;

   localparam logic [31:0] BASE    = 32'h0200_0000;
   localparam logic [15:0] BASE_HI = 16'h0200;
`ifdef CLINT_MTIME_WRITE_EN
   localparam bit MTIME_WR = 1'b1;
`else
   localparam bit MTIME_WR = 1'b0;
`endif

   logic        clk      = 1'b0;
   logic        resetn   = 1'b0;
   logic        memValid = 1'b0;
   logic [3:0]  memWstrb = 4'h0;
   logic [31:0] memAddr  = 32'h0;
   logic [31:0] memWdata = 32'h0;
   logic [1:0]  rdy;
   logic [1:0]  flt;
   logic [1:0]  irq3;
   logic [1:0]  irq7;
   logic [63:0] rdat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clint_mem_responder #(.BASE_ADDR(BASE), .TICK_DIV(1)) dutDiv1 (
      .clk(clk), .resetn(resetn), .mem_valid(memValid), .mem_ready(rdy[0]),
      .mem_wstrb(memWstrb), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(rdat[31:0]), .access_fault(flt[0]), .IRQ3(irq3[0]), .IRQ7(irq7[0]));

   clint_mem_responder #(.BASE_ADDR(BASE), .TICK_DIV(4)) dutDiv4 (
      .clk(clk), .resetn(resetn), .mem_valid(memValid), .mem_ready(rdy[1]),
      .mem_wstrb(memWstrb), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(rdat[63:32]), .access_fault(flt[1]), .IRQ3(irq3[1]), .IRQ7(irq7[1]));

   // ---------------- reference model ----------------
   int               mEdges;
   logic             mExpReady;
   logic             mExpFault;
   logic [1:0][31:0] mExpRdata;
   logic [1:0][63:0] mMtime;
   logic [1:0][63:0] mCmp;
   logic [1:0]       mMsip;
   logic [1:0]       mIrq7;
   logic             modelAccept;
   logic             modelWrite;

   function automatic logic [31:0] laneMerge(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
      return res;
   endfunction

   function automatic logic isMapped(input logic [15:0] off);
      return (off == 16'h0000) || (off == 16'h4000) || (off == 16'h4004) ||
             (off == 16'hBFF8) || (off == 16'hBFFC);
   endfunction

   function automatic logic [31:0] regRead(input logic [15:0] off, input logic [63:0] mt,
                                           input logic [63:0] cmp, input logic ms);
      case (off)
         16'h0000: return {31'b0, ms};
         16'h4000: return cmp[31:0];
         16'h4004: return cmp[63:32];
         16'hBFF8: return mt[31:0];
         16'hBFFC: return mt[63:32];
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [63:0] nextTime(input logic [63:0] mt, input logic tick, input logic wr,
                                            input logic [15:0] off, input logic [31:0] wd,
                                            input logic [3:0] st);
      logic [63:0] t;
      t = tick ? mt + 64'd1 : mt;
      if (wr && off == 16'hBFF8) t[31:0]  = laneMerge(t[31:0], wd, st);
      if (wr && off == 16'hBFFC) t[63:32] = laneMerge(t[63:32], wd, st);
      return t;
   endfunction

   assign modelAccept = !mExpReady && memValid && (memAddr[31:16] == BASE_HI);
   assign modelWrite  = modelAccept && isMapped(memAddr[15:0]) && (memWstrb != 4'h0);

   // Model state advances on every edge from the pre-edge register values
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mEdges    <= 0;
         mExpReady <= 1'b0;
         mExpFault <= 1'b0;
         mExpRdata <= '0;
         mMtime    <= '0;
         mCmp      <= {2{64'hFFFF_FFFF_FFFF_FFFF}};
         mMsip     <= 2'b00;
         mIrq7     <= 2'b00;
      end else begin
         mEdges    <= mEdges + 1;
         mExpReady <= modelAccept;
         mExpFault <= modelAccept && !isMapped(memAddr[15:0]);
         for (int k = 0; k < 2; k++) begin
            mExpRdata[k] <= modelAccept ? regRead(memAddr[15:0], mMtime[k], mCmp[k], mMsip[k]) : 32'h0;
            mMtime[k]    <= nextTime(mMtime[k], ((mEdges + 1) % (k == 0 ? 1 : 4)) == 0,
                                     MTIME_WR && modelWrite, memAddr[15:0], memWdata, memWstrb);
            if (modelWrite && memAddr[15:0] == 16'h4000) mCmp[k][31:0]  <= laneMerge(mCmp[k][31:0], memWdata, memWstrb);
            if (modelWrite && memAddr[15:0] == 16'h4004) mCmp[k][63:32] <= laneMerge(mCmp[k][63:32], memWdata, memWstrb);
            if (modelWrite && memAddr[15:0] == 16'h0000 && memWstrb[0]) mMsip[k] <= memWdata[0];
            mIrq7[k] <= (mMtime[k] >= mCmp[k]);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of both responders against the model
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("ready[%0d]", k), {31'b0, rdy[k]}, {31'b0, mExpReady});
         if (mExpReady) begin
            checkOutput($sformatf("fault[%0d]", k), {31'b0, flt[k]}, {31'b0, mExpFault});
            checkOutput($sformatf("rdata[%0d]", k), rdat[k*32 +: 32], mExpRdata[k]);
         end else begin
            checkOutput($sformatf("idle fault[%0d]", k), {31'b0, flt[k]}, 32'h0);
         end
         checkOutput($sformatf("irq3[%0d]", k), {31'b0, irq3[k]}, {31'b0, mMsip[k]});
         checkOutput($sformatf("irq7[%0d]", k), {31'b0, irq7[k]}, {31'b0, mIrq7[k]});
      end
   end

   // One bus transfer, started on a falling edge and sampled one cycle later
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                                output logic [31:0] rd0, output logic [31:0] rd1,
                                output logic [1:0] ready, output logic [1:0] fault);
      memAddr  = addr;
      memWdata = wdata;
      memWstrb = wstrb;
      memValid = 1'b1;
      @(negedge clk);
      ready    = rdy;
      fault    = flt;
      rd0      = rdat[31:0];
      rd1      = rdat[63:32];
      memValid = 1'b0;
      memWstrb = 4'h0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [31:0] r0;
      logic [31:0] r1;
      logic [1:0]  rr;
      logic [1:0]  ff;
      logic        sawReady;
      int          irqEdge;
      int          n;

      repeat (3) @(negedge clk);
      checkOutput("reset ready", {30'b0, rdy}, 32'h0);
      checkOutput("reset irq", {28'b0, irq3, irq7}, 32'h0);
      resetn = 1'b1;

      // Reading mtime right after release returns the cycle count
      applyStimulus(BASE + 32'hBFF8, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t1 ready", {30'b0, rr}, 32'h3);
      checkOutput("t1 fault", {30'b0, ff}, 32'h0);
      checkOutput("t1 mtime lo div1", r0, 32'd0);
      applyStimulus(BASE + 32'hBFF8, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t1 mtime lo div1 again", r0, 32'd2);
      checkOutput("t1 mtime lo div4", r1, 32'd0);
      applyStimulus(BASE + 32'hBFFC, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t1 mtime hi", r0, 32'd0);

      // msip drives IRQ3, and only bit 0 is stored
      applyStimulus(BASE, 32'h1, 4'hF, r0, r1, rr, ff);
      checkOutput("t2 irq3 set", {30'b0, irq3}, 32'h3);
      applyStimulus(BASE, 32'hFFFF_FFFF, 4'hF, r0, r1, rr, ff);
      applyStimulus(BASE, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t2 msip read", r0, 32'h1);
      applyStimulus(BASE, 32'h0, 4'hF, r0, r1, rr, ff);
      checkOutput("t2 irq3 clear", {30'b0, irq3}, 32'h0);
      applyStimulus(BASE, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t2 msip read 0", r0, 32'h0);

      // With TICK_DIV=4, mtime reaches 100 at edge 400, so IRQ7 follows at edge 401
      applyStimulus(BASE + 32'h4004, 32'h0, 4'hF, r0, r1, rr, ff);
      applyStimulus(BASE + 32'h4000, 32'd100, 4'hF, r0, r1, rr, ff);
      irqEdge = -1;
      for (int i = 0; i < 1000 && irqEdge < 0; i++) begin
         @(negedge clk);
         if (irq7[1]) irqEdge = mEdges;
      end
      checkOutput("t3 irq7 div4 edge", 32'(irqEdge), 32'd401);
      applyStimulus(BASE + 32'h4004, 32'h1, 4'hF, r0, r1, rr, ff);
      checkOutput("t3 irq7 cleared", {30'b0, irq7}, 32'h0);

      // Unmapped and misaligned offsets fault. Out-of-window requests get no response.
      applyStimulus(BASE + 32'h0008, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t4 0x8 ready", {30'b0, rr}, 32'h3);
      checkOutput("t4 0x8 fault", {30'b0, ff}, 32'h3);
      checkOutput("t4 0x8 rdata", r0 | r1, 32'h0);
      applyStimulus(BASE + 32'h4002, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t4 0x4002 fault", {30'b0, ff}, 32'h3);
      checkOutput("t4 0x4002 rdata", r0 | r1, 32'h0);
      memAddr  = 32'h1000_0000;
      memValid = 1'b1;
      sawReady = 1'b0;
      repeat (16) begin
         @(negedge clk);
         if (rdy != 2'b00) sawReady = 1'b1;
      end
      memValid = 1'b0;
      checkOutput("t4 foreign no ready", {31'b0, sawReady}, 32'h0);
      @(negedge clk);

      // mtime writes: with writes enabled, mtime becomes all-ones and wraps. Otherwise it keeps counting.
      n = mEdges;
      applyStimulus(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, r0, r1, rr, ff);
      checkOutput("t5 hi write ack", {30'b0, rr, ff}, {28'b0, 2'b11, 2'b00});
      applyStimulus(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r0, r1, rr, ff);
      checkOutput("t5 lo write ack", {30'b0, rr, ff}, {28'b0, 2'b11, 2'b00});
      applyStimulus(BASE + 32'hBFFC, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t5 mtime hi div1", r0, 32'h0);
      applyStimulus(BASE + 32'hBFF8, 32'h0, 4'h0, r0, r1, rr, ff);
`ifdef CLINT_MTIME_WRITE_EN
      checkOutput("t5 mtime lo after wrap", r0, 32'd2);
`else
      checkOutput("t5 mtime lo unchanged", r0, 32'(n + 6));
`endif

      // Asynchronous reset during ACK
      applyStimulus(BASE, 32'h1, 4'hF, r0, r1, rr, ff);
      memAddr  = BASE;
      memWstrb = 4'h0;
      memValid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t6 ready in ack", {30'b0, rdy}, 32'h3);
      resetn = 1'b0;
      #1;
      checkOutput("t6 ready dropped", {30'b0, rdy}, 32'h0);
      memValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      checkOutput("t6 irqs after reset", {28'b0, irq3, irq7}, 32'h0);
      applyStimulus(BASE, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t6 msip reset", r0 | r1, 32'h0);
      applyStimulus(BASE + 32'h4000, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t6 cmp lo reset", r0 & r1, 32'hFFFF_FFFF);
      applyStimulus(BASE + 32'h4004, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t6 cmp hi reset", r0 & r1, 32'hFFFF_FFFF);
      applyStimulus(BASE + 32'hBFF8, 32'h0, 4'h0, r0, r1, rr, ff);
      checkOutput("t6 mtime div1", r0, 32'd6);
      checkOutput("t6 mtime div4", r1, 32'd1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
